input_mems: RTL and testbench

- Input buffering stage directly upstream of the MAC in the matrix-vector datapath.
- Accepts a stream of signed INW-bit words over a valid/ready handshake and stores an optional new matrix W (R x C, row-major) plus a vector X (C words) in internal memories.
- Flags when the operands are loaded and serves random-access reads to the compute controller that drives the MAC's in0/in1.
- Refuses new input until the controller signals that compute is finished.

---
 rtl/input_mems_pkg.sv | 16 +
 rtl/input_mems_mem_sp.sv | 24 ++
 rtl/input_mems.sv | 148 ++++++++++++++
 tb/tb_input_mems.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_mems_pkg.sv
// Shared types and default sizes for the operand-buffering stage ahead of the MAC.
// These defaults are meant to be shared with the MAC and the compute controller.
package input_mems_pkg;

   localparam int INW_DEF = 16;
   localparam int R_DEF   = 8;
   localparam int C_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      LOAD_X = 2'd2,
      LOADED = 2'd3
   } state_t;

endpackage

// File: rtl/input_mems_mem_sp.sv
// Single-port synchronous RAM. The read data is registered, so it appears one cycle after the address.
// A write and a read share the same address port.
module mem_sp #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 64,
   localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/input_mems.sv
// Operand buffer ahead of the MAC: stores an optional matrix W and then a vector X from a stream, and serves reads to the controller.
// Defining INPUT_MEMS_LOADCNT_EN adds a 16-bit load_count output that counts completed loads.
//
// state  | meaning
// IDLE   | ready; the first beat selects matrix+vector (TUSER=1) or vector only
// LOAD_W | collecting W words, row-major
// LOAD_X | collecting X words
// LOADED | operands readable; input is blocked until compute_finished
module input_mems
   import input_mems_pkg::*;
#(
   parameter int INW    = INW_DEF,
   parameter int R      = R_DEF,
   parameter int C      = C_DEF,
   parameter int WADDRW = $clog2(R*C),
   parameter int XADDRW = $clog2(C)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [INW-1:0]    AXIS_TDATA,
   input  logic                     AXIS_TVALID,
   input  logic                     AXIS_TUSER,
   output logic                     AXIS_TREADY,
   output logic                     inputs_loaded,
   input  logic                     compute_finished,
   input  logic [WADDRW-1:0]        W_read_addr,
   output logic signed [INW-1:0]    W_data,
   input  logic [XADDRW-1:0]        X_read_addr,
   output logic signed [INW-1:0]    X_data
`ifdef INPUT_MEMS_LOADCNT_EN
   ,
   output logic [15:0]              load_count
`endif
);

   localparam logic [WADDRW-1:0] W_LAST = WADDRW'(R*C-1);
   localparam logic [XADDRW-1:0] X_LAST = XADDRW'(C-1);

   state_t            state;
   state_t            state_nxt;
   logic [WADDRW-1:0] w_cnt;
   logic [XADDRW-1:0] x_cnt;
   logic              tready_q;
   logic              loaded_q;
   logic              beat;
   logic              w_we;
   logic              x_we;
   logic [WADDRW-1:0] w_addr;
   logic [XADDRW-1:0] x_addr;
   logic [INW-1:0]    w_rdata;
   logic [INW-1:0]    x_rdata;

   assign beat = AXIS_TVALID && tready_q;
   assign w_we = beat && ((state == IDLE && AXIS_TUSER) || state == LOAD_W);
   assign x_we = beat && ((state == IDLE && !AXIS_TUSER) || state == LOAD_X);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (beat) begin
               if (AXIS_TUSER) begin
                  state_nxt = (W_LAST == '0) ? LOAD_X : LOAD_W;
               end else begin
                  state_nxt = (X_LAST == '0) ? LOADED : LOAD_X;
               end
            end
         end
         LOAD_W: begin
            if (beat && w_cnt == W_LAST) begin
               state_nxt = LOAD_X;
            end
         end
         LOAD_X: begin
            if (beat && x_cnt == X_LAST) begin
               state_nxt = LOADED;
            end
         end
         LOADED: begin
            if (compute_finished) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters wrap to 0 on their last beat, so each following state starts from address 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         w_cnt    <= '0;
         x_cnt    <= '0;
         tready_q <= 1'b0;
         loaded_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         tready_q <= (state_nxt != LOADED);
         loaded_q <= (state_nxt == LOADED);
         if (w_we) begin
            w_cnt <= (w_cnt == W_LAST) ? '0 : w_cnt + 1'b1;
         end else if (state_nxt == IDLE) begin
            w_cnt <= '0;
         end
         if (x_we) begin
            x_cnt <= (x_cnt == X_LAST) ? '0 : x_cnt + 1'b1;
         end else if (state_nxt == IDLE) begin
            x_cnt <= '0;
         end
      end
   end

`ifdef INPUT_MEMS_LOADCNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         load_count <= 16'd0;
      end else if (state != LOADED && state_nxt == LOADED) begin
         load_count <= load_count + 16'd1;
      end
   end
`endif

   // The write counter owns the RAM address while a beat is being stored.
   assign w_addr = w_we ? w_cnt : W_read_addr;
   assign x_addr = x_we ? x_cnt : X_read_addr;

   mem_sp #(.WIDTH(INW), .SIZE(R*C)) u_w_mem (
      .clk   (clk),
      .we    (w_we),
      .addr  (w_addr),
      .wdata (AXIS_TDATA),
      .rdata (w_rdata)
   );

   mem_sp #(.WIDTH(INW), .SIZE(C)) u_x_mem (
      .clk   (clk),
      .we    (x_we),
      .addr  (x_addr),
      .wdata (AXIS_TDATA),
      .rdata (x_rdata)
   );

   assign AXIS_TREADY   = tready_q;
   assign inputs_loaded = loaded_q;
   assign W_data        = w_rdata;
   assign X_data        = x_rdata;

endmodule

// File: tb/tb_input_mems.sv
// Directed bench for input_mems: it runs several loads and then checks the stored words through a table of read vectors.
// It also checks load_count when INPUT_MEMS_LOADCNT_EN is defined.
module tb_input_mems;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] AXIS_TDATA;
   logic               AXIS_TVALID;
   logic               AXIS_TUSER;
   logic               AXIS_TREADY;
   logic               inputs_loaded;
   logic               compute_finished;
   logic [5:0]         W_read_addr;
   logic signed [15:0] W_data;
   logic [2:0]         X_read_addr;
   logic signed [15:0] X_data;
`ifdef INPUT_MEMS_LOADCNT_EN
   logic [15:0]        load_count;
`endif

   input_mems #(.INW(16), .R(8), .C(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .AXIS_TDATA       (AXIS_TDATA),
      .AXIS_TVALID      (AXIS_TVALID),
      .AXIS_TUSER       (AXIS_TUSER),
      .AXIS_TREADY      (AXIS_TREADY),
      .inputs_loaded    (inputs_loaded),
      .compute_finished (compute_finished),
      .W_read_addr      (W_read_addr),
      .W_data           (W_data),
      .X_read_addr      (X_read_addr),
      .X_data           (X_data)
`ifdef INPUT_MEMS_LOADCNT_EN
      ,
      .load_count       (load_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int acc   = 0;

   always @(posedge clk) begin
      if (!reset && AXIS_TVALID && AXIS_TREADY) acc++;
   end

   typedef struct {
      int    grp;
      bit    is_w;
      int    addr;
      int    exp;
   } rd_t;

   rd_t rv [$];

   int  last_w, last_x;
   bit  have_w, have_x;

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic signed [15:0] d, input logic user, input int gap);
      int n;
      repeat (gap) begin
         @(negedge clk);
         AXIS_TVALID = 1'b0;
         AXIS_TDATA  = 16'h7FFF;
         AXIS_TUSER  = ~user;
      end
      @(negedge clk);
      AXIS_TVALID = 1'b1;
      AXIS_TDATA  = d;
      AXIS_TUSER  = user;
      n = 0;
      while (!AXIS_TREADY && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL push_timeout: got tready=0 want tready=1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      AXIS_TVALID = 1'b0;
   endtask

   task automatic load(input int w0, input bit with_w, input int x0, input int xstep,
                       input bit gaps, input bit spurious, input string tag);
      int a0;
      int nexp;
      a0   = acc;
      nexp = with_w ? 72 : 8;
      if (with_w) begin
         for (int i = 0; i < 64; i++) begin
            push(16'(w0 + i), (i == 0) ? 1'b1 : 1'(i % 2), gaps ? int'($urandom_range(0, 2)) : 0);
         end
      end
      for (int j = 0; j < 8; j++) begin
         if (spurious && j == 3) begin
            @(negedge clk);
            compute_finished = 1'b1;
            @(negedge clk);
            compute_finished = 1'b0;
            chk({tag, "_spurious_tready"}, AXIS_TREADY, 1);
            chk({tag, "_spurious_loaded"}, inputs_loaded, 0);
         end
         if (j == 7) chk({tag, "_loaded_early"}, inputs_loaded, 0);
         push(16'(x0 + j * xstep), 1'b0, gaps ? int'($urandom_range(0, 1)) : 0);
      end
      chk({tag, "_loaded"}, inputs_loaded, 1);
      chk({tag, "_tready_low"}, AXIS_TREADY, 0);
      chk({tag, "_beats"}, acc - a0, nexp);
      have_w = 1'b0;
      have_x = 1'b0;
   endtask

   task automatic finish_compute();
      @(negedge clk);
      compute_finished = 1'b1;
      @(posedge clk);
      #1;
      chk("finish_tready", AXIS_TREADY, 1);
      chk("finish_loaded", inputs_loaded, 0);
      @(negedge clk);
      compute_finished = 1'b0;
   endtask

   task automatic run_reads(input int grp);
      foreach (rv[k]) begin
         if (rv[k].grp == grp) begin
            @(negedge clk);
            if (rv[k].is_w) W_read_addr = 6'(rv[k].addr);
            else            X_read_addr = 3'(rv[k].addr);
            #1;
            if (rv[k].is_w && have_w)  chk($sformatf("g%0d_w_latency", grp), W_data, last_w);
            if (!rv[k].is_w && have_x) chk($sformatf("g%0d_x_latency", grp), X_data, last_x);
            @(posedge clk);
            #1;
            if (rv[k].is_w) begin
               chk($sformatf("g%0d_W[%0d]", grp, rv[k].addr), W_data, rv[k].exp);
               last_w = rv[k].exp;
               have_w = 1'b1;
            end else begin
               chk($sformatf("g%0d_X[%0d]", grp, rv[k].addr), X_data, rv[k].exp);
               last_x = rv[k].exp;
               have_x = 1'b1;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      rv = '{
         '{0, 1, 0, 1},   '{0, 1, 9, 10},   '{0, 1, 63, 64},
         '{0, 0, 0, 100}, '{0, 0, 3, 103},  '{0, 0, 7, 107},
         '{1, 1, 9, 10},  '{1, 1, 0, 1},    '{1, 1, 63, 64},  '{1, 1, 40, 41},
         '{1, 0, 7, -8},  '{1, 0, 0, -1},
         '{2, 1, 0, 300}, '{2, 1, 17, 317}, '{2, 1, 63, 363},
         '{2, 0, 5, 405}, '{2, 0, 7, 407},
         '{3, 1, 0, 200}, '{3, 1, 19, 219}, '{3, 1, 63, 263},
         '{3, 0, 0, 264}, '{3, 0, 7, 271},
         '{4, 1, 1, 601}, '{4, 0, 2, 702},  '{4, 0, 3, 703},  '{4, 0, 7, 707}
      };
      have_w           = 1'b0;
      have_x           = 1'b0;
      reset            = 1'b1;
      AXIS_TDATA       = '0;
      AXIS_TVALID      = 1'b0;
      AXIS_TUSER       = 1'b0;
      compute_finished = 1'b0;
      W_read_addr      = '0;
      X_read_addr      = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_tready", AXIS_TREADY, 0);
      chk("reset_loaded", inputs_loaded, 0);
`ifdef INPUT_MEMS_LOADCNT_EN
      chk("reset_load_count", load_count, 0);
`endif
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_tready", AXIS_TREADY, 1);

      // Full load of W and X, then confirm that a beat offered while LOADED is not accepted.
      load(1, 1'b1, 100, 1, 1'b0, 1'b0, "full");
      a0 = acc;
      @(negedge clk);
      AXIS_TVALID = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      AXIS_TVALID = 1'b0;
      chk("loaded_blocks_beats", acc - a0, 0);
      chk("loaded_tready_held", AXIS_TREADY, 0);
      run_reads(0);

      finish_compute();
      load(0, 1'b0, -1, -1, 1'b0, 1'b0, "vec");
      run_reads(1);

      finish_compute();
      load(300, 1'b1, 400, 1, 1'b1, 1'b0, "gaps");
      run_reads(2);
`ifdef INPUT_MEMS_LOADCNT_EN
      chk("load_count_3", load_count, 3);
`endif

      // Reset in the middle of a W load discards the partial load.
      finish_compute();
      for (int i = 0; i < 20; i++) push(16'(500 + i), (i == 0) ? 1'b1 : 1'b0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_tready", AXIS_TREADY, 0);
      chk("midreset_loaded", inputs_loaded, 0);
`ifdef INPUT_MEMS_LOADCNT_EN
      chk("midreset_load_count", load_count, 0);
`endif
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_idle_tready", AXIS_TREADY, 1);
      load(200, 1'b1, 264, 1, 1'b0, 1'b0, "rst");
      run_reads(3);

      finish_compute();
      load(600, 1'b1, 700, 1, 1'b0, 1'b1, "spur");
      run_reads(4);
`ifdef INPUT_MEMS_LOADCNT_EN
      chk("load_count_2", load_count, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
